// File: rtl/gpu_pkg.sv
// gpu_pkg: shared opcodes, FSM states and instruction field layout for gpu_core.
package gpu_pkg;
    localparam int INSTR_W = 16;
    localparam int OPC_W = 4;
    localparam int OPD_W = 12;
    typedef enum logic [OPC_W-1:0] {
        OP_NOP = 4'h0, OP_SET_COLOR = 4'h1, OP_SET_X = 4'h2, OP_SET_Y = 4'h3,
        OP_DRAW = 4'h4, OP_HLINE = 4'h5, OP_CLEAR = 4'h6, OP_JMP = 4'h7,
        OP_SET_CNT = 4'h8, OP_DJNZ = 4'h9, OP_HALT = 4'hF
    } opcode_e;
    localparam logic [1:0] S_IDLE = 2'd0, S_FETCH = 2'd1, S_EXEC = 2'd2, S_FILL = 2'd3;
    function automatic logic is_illegal(input logic [OPC_W-1:0] opc);
        return opc >= 4'hA && opc <= 4'hE;
    endfunction
endpackage

// File: rtl/gpu_dp_ram.sv
// gpu_dp_ram: simple dual-port RAM, one write port and one registered read-first read port.
module gpu_dp_ram #(
    parameter int DW = 8,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [2**AW];
    // writes are dropped during reset so an interrupted fill stops cleanly
    always_ff @(posedge clk) begin
        if (we && !reset) mem[waddr] <= wdata;
        rdata <= reset ? '0 : mem[raddr];
    end
endmodule

// File: rtl/gpu_core.sv
// gpu_core: pixel GPU with program RAM, span/clear fills, counted loops and a display read port.
module gpu_core
    import gpu_pkg::*;
#(
    parameter int COORD_W = 4,
    parameter int COLOR_W = 8,
    parameter int PC_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 run,
    input  logic                 prog_we,
    input  logic [PC_W-1:0]      prog_addr,
    input  logic [INSTR_W-1:0]   prog_wdata,
    input  logic [2*COORD_W-1:0] rd_addr,
    output logic [COLOR_W-1:0]   rd_data,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);
    localparam int FB_AW = 2*COORD_W;
    logic [1:0] state;
    logic [PC_W-1:0] pc;
    logic [COLOR_W-1:0] rcolor;
    logic [COORD_W-1:0] rx, ry, room, hlen;
    logic [OPD_W-1:0] rcnt, cnt_dec, opd;
    logic [OPC_W-1:0] opc;
    logic [FB_AW-1:0] fill_addr, fill_left, fb_waddr;
    logic [INSTR_W-1:0] instr;
    logic idle, exec, fill, fb_we;
    assign idle = state == S_IDLE;
    assign exec = state == S_EXEC;
    assign fill = state == S_FILL;
    assign opc = instr[INSTR_W-1 -: OPC_W];
    assign opd = instr[OPD_W-1:0];
    assign busy = !idle;
    assign done = exec && opc == OP_HALT;
    assign cnt_dec = rcnt - 1'b1;
    // span length minus one, clipped at the right edge of the row
    assign room = ~rx;
    assign hlen = opd[COORD_W-1:0] < room ? opd[COORD_W-1:0] : room;
    assign fb_we = fill || (exec && opc == OP_DRAW);
    assign fb_waddr = fill ? fill_addr : {ry, rx};
    gpu_dp_ram #(.DW(INSTR_W), .AW(PC_W)) u_prog (
        .clk(clk), .reset(reset), .we(idle && prog_we), .waddr(prog_addr),
        .wdata(prog_wdata), .raddr(pc), .rdata(instr)
    );
    gpu_dp_ram #(.DW(COLOR_W), .AW(FB_AW)) u_fb (
        .clk(clk), .reset(reset), .we(fb_we), .waddr(fb_waddr),
        .wdata(rcolor), .raddr(rd_addr), .rdata(rd_data)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            pc <= '0;
            rcolor <= '0;
            rx <= '0;
            ry <= '0;
            rcnt <= '0;
            err <= 1'b0;
            fill_addr <= '0;
            fill_left <= '0;
        end else begin
            case (state)
                S_IDLE: if (run) begin
                    state <= S_FETCH;
                    pc <= '0;
                    err <= 1'b0;
                end
                S_FETCH: begin
                    pc <= pc + 1'b1;
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    state <= S_FETCH;
                    if (is_illegal(opc)) err <= 1'b1;
                    case (opc)
                        OP_SET_COLOR: rcolor <= opd[COLOR_W-1:0];
                        OP_SET_X: rx <= opd[COORD_W-1:0];
                        OP_SET_Y: ry <= opd[COORD_W-1:0];
                        OP_HLINE: begin
                            fill_addr <= {ry, rx};
                            fill_left <= {{COORD_W{1'b0}}, hlen};
                            state <= S_FILL;
                        end
                        OP_CLEAR: begin
                            fill_addr <= '0;
                            fill_left <= '1;
                            state <= S_FILL;
                        end
                        OP_JMP: pc <= opd[PC_W-1:0];
                        OP_SET_CNT: rcnt <= opd;
                        OP_DJNZ: begin
                            rcnt <= cnt_dec;
                            if (cnt_dec != '0) pc <= opd[PC_W-1:0];
                        end
                        OP_HALT: state <= S_IDLE;
                        default: ;
                    endcase
                end
                default: begin
                    fill_addr <= fill_addr + 1'b1;
                    fill_left <= fill_left - 1'b1;
                    if (fill_left == '0) state <= S_FETCH;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_gpu_core.sv
// tb_gpu_core: randomized and directed checks of gpu_core against an instruction-level model.
module tb_gpu_core;
    logic clk = 1'b0, reset = 1'b1, run = 1'b0, prog_we = 1'b0;
    logic [7:0] prog_addr = '0, rd_addr = '0;
    logic [15:0] prog_wdata = '0;
    logic [7:0] rd_data;
    logic busy, done, err;

    gpu_core #(.COORD_W(4), .COLOR_W(8), .PC_W(8)) dut (
        .clk(clk), .reset(reset), .run(run), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_wdata(prog_wdata), .rd_addr(rd_addr), .rd_data(rd_data),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {bit busy; bit done; bit err; bit we; int waddr; int wdata;} ent_t;
    ent_t q[$];
    int n_tests = 0, n_fail = 0;
    bit chk_en = 0, idle_err = 0, rd_known = 0;
    int exp_rd = 0;
    int fb_m[256];
    bit fb_v[256];
    logic [15:0] prog_m[256];
    int m_col = 0, m_x = 0, m_y = 0, m_cnt = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void push(bit b, bit d, bit e, bit w, int a, int c);
        ent_t x;
        x.busy = b; x.done = d; x.err = e; x.we = w; x.waddr = a; x.wdata = c;
        q.push_back(x);
    endfunction

    // Instruction-level interpreter: each instruction expands to its cycle cost and pixel writes.
    task automatic model_run();
        int pc = 0, cyc = 0, op, opd;
        bit e = 0;
        push(0, 0, idle_err, 0, 0, 0);
        while (cyc < 5000) begin
            op = int'(prog_m[pc][15:12]);
            opd = int'(prog_m[pc][11:0]);
            pc = (pc + 1) % 256;
            cyc += 2;
            push(1, 0, e, 0, 0, 0);
            if (op == 15) begin
                push(1, 1, e, 0, 0, 0);
                break;
            end
            push(1, 0, e, op == 4, m_y * 16 + m_x, m_col);
            case (op)
                1: m_col = opd % 256;
                2: m_x = opd % 16;
                3: m_y = opd % 16;
                5: for (int x = m_x; x <= m_x + opd % 16 && x <= 15; x++) begin
                    push(1, 0, e, 1, m_y * 16 + x, m_col);
                    cyc++;
                end
                6: for (int a = 0; a < 256; a++) push(1, 0, e, 1, a, m_col);
                7: pc = opd % 256;
                8: m_cnt = opd;
                9: begin
                    m_cnt = (m_cnt + 4095) % 4096;
                    if (m_cnt != 0) pc = opd % 256;
                end
                10, 11, 12, 13, 14: e = 1;
                default: ;
            endcase
        end
        idle_err = e;
    endtask

    // Per-cycle compare: control outputs against the model timeline, rd_data against the model framebuffer.
    always @(negedge clk) begin
        ent_t e;
        e.busy = 0; e.done = 0; e.err = idle_err; e.we = 0; e.waddr = 0; e.wdata = 0;
        if (q.size() != 0) e = q.pop_front();
        if (chk_en) begin
            chk("busy", int'(busy), int'(e.busy));
            chk("done", int'(done), int'(e.done));
            chk("err", int'(err), int'(e.err));
            if (rd_known) chk("rd_data", int'(rd_data), exp_rd);
        end
        rd_known = reset || fb_v[rd_addr];
        exp_rd = reset ? 0 : fb_m[rd_addr];
        if (reset) begin
            q.delete();
            idle_err = 0;
        end else if (e.we) begin
            fb_m[e.waddr] = e.wdata;
            fb_v[e.waddr] = 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        rd_addr = 8'($urandom);
    endtask

    task automatic load(input logic [7:0] a, input logic [15:0] w);
        prog_we = 1; prog_addr = a; prog_wdata = w; prog_m[a] = w;
        tick();
        prog_we = 0;
    endtask

    task automatic load_prog(input logic [15:0] p[$]);
        foreach (p[i]) load(8'(i), p[i]);
    endtask

    task automatic rd(input string n, input logic [7:0] a, input int exp);
        rd_addr = a;
        @(posedge clk);
        #1;
        chk(n, int'(rd_data), exp);
    endtask

    task automatic run_prog(input bit wsame, input logic [7:0] wa, input logic [15:0] wd,
                            input bit inject, output int nb, output int nd, output int dat);
        nb = 0; nd = 0; dat = 0;
        run = 1;
        if (wsame) begin
            prog_we = 1; prog_addr = wa; prog_wdata = wd; prog_m[wa] = wd;
        end
        model_run();
        tick();
        run = 0; prog_we = 0;
        for (int i = 1; i <= 6000; i++) begin
            if (!busy) break;
            nb++;
            if (done) begin nd++; dat = i; end
            prog_we = inject && i == 3;
            prog_addr = '0; prog_wdata = 16'hF000;
            run = inject && i == 5;
            tick();
            if (i == 6000) chk("timeout", int'(busy), 0);
        end
        prog_we = 0; run = 0;
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int nb, nd, dat, len, op;
        int ops[18] = '{0, 1, 2, 3, 4, 5, 4, 5, 8, 10, 11, 12, 13, 14, 6, 1, 2, 3};
        logic [15:0] p[$];
        repeat (3) @(posedge clk);
        #1;
        reset = 0; chk_en = 1;
        repeat (2) tick();

        load_prog('{16'h1011, 16'h6000});
        run_prog(1, 8'd2, 16'hF000, 0, nb, nd, dat);
        chk("clear_cycles", nb, 262);
        chk("clear_done_count", nd, 1);
        rd("clear_px0", 8'd0, 'h11);
        rd("clear_px255", 8'd255, 'h11);

        load_prog('{16'h115A, 16'h2003, 16'h3002, 16'h4000});
        run_prog(1, 8'd4, 16'hF000, 0, nb, nd, dat);
        chk("pixel_busy_cycles", nb, 10);
        chk("pixel_done_at", dat, 10);
        rd("pixel_px35", 8'd35, 'h5A);
        rd("pixel_px34", 8'd34, 'h11);

        load_prog('{16'h200E, 16'h3001, 16'h1033, 16'h5007, 16'h1044, 16'h3003, 16'h4000});
        run_prog(1, 8'd7, 16'hF000, 0, nb, nd, dat);
        chk("hline_cycles", nb, 18);
        rd("hline_px29", 8'd29, 'h11);
        rd("hline_px30", 8'd30, 'h33);
        rd("hline_px31", 8'd31, 'h33);
        rd("hline_px32", 8'd32, 'h11);
        rd("hline_rx_kept", 8'd62, 'h44);

        load_prog('{16'h8003, 16'h1001, 16'h2000, 16'h3005, 16'h4000, 16'h9004});
        run_prog(1, 8'd6, 16'hF000, 0, nb, nd, dat);
        chk("loop_cycles", nb, 22);
        chk("loop_done_count", nd, 1);
        rd("loop_px80", 8'd80, 'h01);
        load_prog('{16'h9002, 16'hF000, 16'h8001});
        run_prog(1, 8'd3, 16'hF000, 0, nb, nd, dat);
        chk("djnz_zero_wraps", nb, 6);

        load_prog('{16'hA000, 16'h7003, 16'hF000, 16'h1077, 16'h2000, 16'h3000, 16'h4000});
        run_prog(1, 8'd7, 16'hF000, 1, nb, nd, dat);
        chk("illegal_cycles", nb, 14);
        chk("illegal_err_sticky", int'(err), 1);
        rd("illegal_px0", 8'd0, 'h77);
        run_prog(0, 8'd0, 16'h0000, 0, nb, nd, dat);
        chk("busy_load_ignored", nb, 14);

        for (int t = 0; t < 12; t++) begin
            p.delete();
            len = int'($urandom_range(4, 14));
            for (int i = 0; i < len; i++) begin
                op = ops[$urandom_range(0, 17)];
                p.push_back(16'((op << 12) | int'($urandom_range(0, 4095))));
            end
            load_prog(p);
            run_prog(1, 8'(len), 16'hF000, 0, nb, nd, dat);
            chk("random_done_count", nd, 1);
            repeat (int'($urandom_range(0, 3))) tick();
        end

        load_prog('{16'h1011, 16'h6000});
        run_prog(1, 8'd2, 16'hF000, 0, nb, nd, dat);
        load_prog('{16'h1022, 16'h6000});
        run = 1; prog_we = 1; prog_addr = 8'd2; prog_wdata = 16'hF000; prog_m[2] = 16'hF000;
        model_run();
        tick();
        run = 0; prog_we = 0;
        repeat (53) tick();
        reset = 1;
        tick();
        reset = 0;
        m_col = 0; m_x = 0; m_y = 0; m_cnt = 0;
        chk("reset_busy", int'(busy), 0);
        chk("reset_rd_data", int'(rd_data), 0);
        rd("reset_px48", 8'd48, 'h22);
        rd("reset_px49", 8'd49, 'h11);
        rd("reset_px200", 8'd200, 'h11);
        for (int a = 0; a < 256; a++) begin
            rd_addr = 8'(a);
            @(posedge clk);
            #1;
        end
        load_prog('{16'h4000});
        run_prog(1, 8'd1, 16'hF000, 0, nb, nd, dat);
        chk("post_reset_cycles", nb, 4);
        rd("post_reset_px0", 8'd0, 'h00);
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/gpu_core.md
# gpu_core

Parametrised successor to the 8-bit single-cycle pixel GPU. It fetches 16-bit instructions from an internal program RAM and keeps colour, coordinate and loop registers. It adds multi-cycle span and clear fills, counted loops, a halt/done handshake, a host program-load port and a display read port on the framebuffer. It sits between the host/sequencer (program load, `run`) and the display scan-out logic (`rd_addr`/`rd_data`).

## Interface
- `COORD_W`, default 4: bits per X/Y coordinate; framebuffer is 2^COORD_W × 2^COORD_W pixels.
- `COLOR_W`, default 8: pixel width; must be ≤ 12.
- `PC_W`, default 8: program address width; program depth is 2^PC_W; must be ≤ 12.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `run` in 1: start execution at PC 0; honoured only in IDLE.
- `prog_we` in 1: program write strobe; honoured only in IDLE.
- `prog_addr` in PC_W: program write address.
- `prog_wdata` in 16: instruction word.
- `rd_addr` in 2*COORD_W: display read address, {y, x}.
- `rd_data` out COLOR_W: pixel at `rd_addr`, registered.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when HALT executes.
- `err` out 1: sticky illegal-opcode flag; cleared by `reset` or by accepted `run`.

## Operation
- Instruction format: opcode = [15:12], operand = [11:0]. Operand fields are taken from the LSBs.
- 0 NOP: no effect.
- 1 SET_COLOR: Rcolor ← op[COLOR_W-1:0].
- 2 SET_X: Rx ← op[COORD_W-1:0].
- 3 SET_Y: Ry ← op[COORD_W-1:0].
- 4 DRAW: fb[{Ry,Rx}] ← Rcolor.
- 5 HLINE: draw len = op[COORD_W-1:0]+1 pixels at (Rx..Rx+len-1, Ry).
  - Clipped at x = 2^COORD_W-1; no wrap to the next row.
  - Rx is unchanged afterwards.
- 6 CLEAR: every pixel ← Rcolor, in address order 0..2^(2·COORD_W)-1. Rx and Ry are unchanged.
- 7 JMP: PC ← op[PC_W-1:0].
- 8 SET_CNT: Rcnt ← op[11:0].
- 9 DJNZ: Rcnt ← Rcnt-1. If the result is ≠ 0, PC ← op[PC_W-1:0]; otherwise fall through.
  - DJNZ with Rcnt = 0 wraps to 0xFFF and jumps.
- F HALT: pulse `done` and go to IDLE.
- A–E: illegal. Set `err` and execute as NOP.
- PC increments modulo 2^PC_W; execution past the last word wraps to 0.
- FSM states:
  - IDLE: `run` → FETCH, with PC←0 and err←0.
  - FETCH: issue synchronous program read at PC, PC←PC+1 → EXEC.
  - EXEC: decode the registered instruction word.
    - HLINE or CLEAR → FILL (fill address/counter loaded).
    - HALT → IDLE.
    - Otherwise → FETCH.
  - FILL: one framebuffer write per cycle. After the last write → FETCH.
- Control-port conditions:
  - `run` while busy is ignored.
  - `prog_we` while busy is ignored; the program RAM is unchanged.
  - `prog_we` and `run` in the same IDLE cycle: the write is performed, then execution starts.
- Framebuffer read/write collision on the same address in the same cycle: `rd_data` returns the old value (read-first).
- Reset values:
  - State IDLE; PC, Rcolor, Rx, Ry, Rcnt = 0.
  - Outputs: `busy`=0, `done`=0, `err`=0, `rd_data`=0.
  - Program RAM and framebuffer contents are not cleared.
- Reset mid-FILL: writes stop at the reset cycle; pixels not yet written keep their prior values.

## Timing
- Non-fill instruction: 2 cycles (FETCH + EXEC). The DRAW write commits at the end of EXEC.
- HLINE: 2 cycles + number of pixels actually written (after clipping).
- CLEAR: 2 + 2^(2·COORD_W) cycles.
- First FETCH occurs the cycle after `run` is accepted. `busy` rises in that same cycle.
- `done` is high during the HALT EXEC cycle. `busy` falls the following cycle.
- `rd_data` latency is 1 cycle from `rd_addr`, independent of FSM state.

## Structure
- Shared package `gpu_pkg`: opcode enum (`OP_NOP`..`OP_HALT`), FSM state enum, instruction field constants (`INSTR_W`=16, opcode/operand slices).
- One natural sub-module: `gpu_dp_ram`.
  - Parametrised simple dual-port RAM: one write port, one registered read-first read port.
  - Instantiated twice: program RAM (16 × 2^PC_W) and framebuffer (COLOR_W × 2^(2·COORD_W)).
- The core holds the FSM, registers and decode only.

## Test plan
Defaults for all scenarios: COORD_W=4, COLOR_W=8, PC_W=8.
- **Single pixel.** Load {SET_COLOR 0x5A, SET_X 3, SET_Y 2, DRAW, HALT}, pulse `run` → fb[35]=0x5A, other pixels unchanged. `done` pulses 10 cycles after the run cycle; `busy` is high for exactly 10 cycles.
- **HLINE clipping.** SET_X 14, SET_Y 1, SET_COLOR 0x33, HLINE 7 → fb[30]=fb[31]=0x33, fb[32] untouched. Instruction takes 4 cycles; Rx still 14 afterwards.
- **CLEAR.** SET_COLOR 0x11, CLEAR → all 256 pixels = 0x11. CLEAR occupies 258 cycles; `rd_data` mid-fill shows old values for not-yet-written addresses.
- **Counted loop.** SET_CNT 3, SET_COLOR 1, [L:] DRAW, SET_X +incrementing program copy, DJNZ L, HALT → DJNZ branches exactly twice. Final Rcnt=0, `done` asserted once.
- **Reset mid-fill.** Assert `reset` 50 cycles into CLEAR → next cycle `busy`=0 and registers=0. Pixels past the last committed address retain prior contents; a new `run` executes normally.
- **Illegal opcode and busy-time load.** Opcode 0xA → `err`=1, execution continues. `prog_we` during busy leaves the program RAM unchanged. `err` clears on the next accepted `run`.
